// File: rtl/mod_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mod_counter
//
// Parametrised modulo up/down counter. Counts over 0..MAX inclusive, either
// wrapping or saturating at the limits, with a synchronous clamped load, a
// registered one-cycle terminal-count pulse and a registered Gray-coded copy of
// the count that is always cycle-aligned with the binary value.
//
// Parameters:
//   WIDTH     counter width in bits (2..16)
//   MAX       terminal count value (1..2**WIDTH-1)
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous reset, active low
//   en        in   1      count enable (hold when low)
//   up        in   1      direction: 1 = up, 0 = down
//   sat       in   1      limit mode: 0 = wrap, 1 = saturate
//   load      in   1      synchronous load strobe, higher priority than en
//   load_val  in   WIDTH  value to load, clamped to MAX
//   counter   out  WIDTH  registered binary count
//   gray      out  WIDTH  registered Gray code of counter
//   tc        out  1      registered terminal-count pulse
// -----------------------------------------------------------------------------
module mod_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MAX   = (2 ** WIDTH) - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] counter,
   output logic [WIDTH-1:0] gray,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] gray_q,  gray_d;
   logic             tc_q,    tc_d;

   // Loaded values above the terminal count are pulled down to MAX so the
   // counter can never leave the legal range.
   function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] v);
      clamp_to_max = (v > MAX_C) ? MAX_C : v;
   endfunction

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      bin2gray = b ^ (b >> 1);
   endfunction

   // Next-state: load beats enable, enable beats hold.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (load) begin
         count_d = clamp_to_max(load_val);
      end else if (en) begin
         if (up) begin
            if (count_q < MAX_C) begin
               count_d = count_q + ONE_C;
               // In saturate mode the pulse marks arrival at the limit,
               // so it fires once and not while the count is parked there.
               tc_d    = sat && (count_d == MAX_C);
            end else if (!sat) begin
               count_d = '0;
               tc_d    = 1'b1;
            end
         end else begin
            if (count_q != '0) begin
               count_d = count_q - ONE_C;
               tc_d    = sat && (count_d == '0);
            end else if (!sat) begin
               count_d = MAX_C;
               tc_d    = 1'b1;
            end
         end
      end
   end

   // Gray is derived from the next binary value so both registers update on
   // the same edge and never disagree.
   always_comb begin
      gray_d = bin2gray(count_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         gray_q  <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         gray_q  <= gray_d;
         tc_q    <= tc_d;
      end
   end

   assign counter = count_q;
   assign gray    = gray_q;
   assign tc      = tc_q;

endmodule

// File: tb/tb_mod_counter.sv
`timescale 1ns/1ps
module tb_mod_counter;

   typedef struct {
      int cnt;
      int gry;
      bit tc;
   } exp_t;

   localparam int A_MAX = 9;
   localparam int B_MAX = 255;

   logic       clk;
   logic       rst;
   logic       a_en, a_up, a_sat, a_load;
   logic [3:0] a_lv;
   logic [3:0] a_cnt, a_gray;
   logic       a_tc;
   logic       b_en, b_up, b_sat, b_load;
   logic [7:0] b_lv;
   logic [7:0] b_cnt, b_gray;
   logic       b_tc;

   exp_t qa[$];
   exp_t qb[$];
   int   ma, mb;
   int   n_checks, n_fail;

   mod_counter #(.WIDTH(4), .MAX(A_MAX)) dut_a (
      .clk(clk), .rst(rst), .en(a_en), .up(a_up), .sat(a_sat), .load(a_load),
      .load_val(a_lv), .counter(a_cnt), .gray(a_gray), .tc(a_tc)
   );

   mod_counter #(.WIDTH(8)) dut_b (
      .clk(clk), .rst(rst), .en(b_en), .up(b_up), .sat(b_sat), .load(b_load),
      .load_val(b_lv), .counter(b_cnt), .gray(b_gray), .tc(b_tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference behaviour: plain integer arithmetic over the range 0..max.
   function automatic void model_step(input int cur, input bit ld, input bit en,
                                      input bit up, input bit sat, input int lv,
                                      input int max, output int nxt, output bit t);
      nxt = cur;
      t   = 1'b0;
      if (ld) begin
         nxt = (lv > max) ? max : lv;
      end else if (en) begin
         if (up) begin
            if (cur < max) begin
               nxt = cur + 1;
               t   = sat && (nxt == max);
            end else if (!sat) begin
               nxt = 0;
               t   = 1'b1;
            end
         end else begin
            if (cur > 0) begin
               nxt = cur - 1;
               t   = sat && (nxt == 0);
            end else if (!sat) begin
               nxt = max;
               t   = 1'b1;
            end
         end
      end
   endfunction

   function automatic exp_t mk(input int c, input bit t);
      exp_t e;
      e.cnt = c;
      e.gry = c ^ (c >> 1);
      e.tc  = t;
      return e;
   endfunction

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
      end
   endtask

   // One clock: predict the effect of the upcoming edge, then let it happen.
   task automatic tick();
      int na, nb;
      bit ta, tb;
      if (!rst) begin
         ma = 0; mb = 0; ta = 1'b0; tb = 1'b0;
      end else begin
         model_step(ma, a_load, a_en, a_up, a_sat, int'(a_lv), A_MAX, na, ta);
         model_step(mb, b_load, b_en, b_up, b_sat, int'(b_lv), B_MAX, nb, tb);
         ma = na;
         mb = nb;
      end
      qa.push_back(mk(ma, ta));
      qb.push_back(mk(mb, tb));
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Asserted between edges; outputs must clear before the next edge.
   task automatic async_reset();
      #1;
      ma = 0;
      mb = 0;
      qa.push_back(mk(0, 1'b0));
      qb.push_back(mk(0, 1'b0));
      rst = 1'b0;
   endtask

   // Monitor: whenever the outputs may have changed, compare against the queue.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or negedge rst);
         #1;
         while (qa.size() > 0) begin
            e = qa.pop_front();
            check("A counter", int'(a_cnt), e.cnt);
            check("A gray", int'(a_gray), e.gry);
            check("A tc", int'(a_tc), int'(e.tc));
         end
         while (qb.size() > 0) begin
            e = qb.pop_front();
            check("B counter", int'(b_cnt), e.cnt);
            check("B gray", int'(b_gray), e.gry);
            check("B tc", int'(b_tc), int'(e.tc));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      ma = 0; mb = 0;
      rst = 1'b0;
      a_en = 0; a_up = 1; a_sat = 0; a_load = 0; a_lv = '0;
      b_en = 0; b_up = 1; b_sat = 0; b_load = 0; b_lv = '0;

      // Reset, then free count 0..9 and wrap.
      ticks(3);
      rst = 1'b1;
      a_en = 1; a_up = 1; a_sat = 0;
      ticks(11);

      // Down-wrap from 1.
      a_load = 1; a_lv = 4'd1; a_en = 0;
      tick();
      a_load = 0; a_en = 1; a_up = 0;
      ticks(3);

      // Saturate up from 7, then back down.
      a_sat = 1; a_load = 1; a_lv = 4'd7;
      tick();
      a_load = 0; a_en = 1; a_up = 1;
      ticks(5);
      a_up = 0;
      ticks(2);

      // Clamp and load priority.
      a_sat = 0; a_load = 1; a_en = 1; a_lv = 4'd15;
      tick();
      a_lv = 4'd3; a_up = 1;
      tick();

      // Hold at 5, count a little, then async reset mid-count.
      a_lv = 4'd5;
      tick();
      a_load = 0; a_en = 0;
      ticks(4);
      a_en = 1; a_up = 1;
      b_load = 1; b_lv = 8'd254;
      tick();
      b_load = 0; b_en = 1; b_up = 1; b_sat = 0;
      ticks(2);
      async_reset();
      ticks(2);
      rst = 1'b1;

      // Full-width wrap on the 8-bit instance.
      b_load = 1; b_lv = 8'd254; b_en = 1;
      tick();
      b_load = 0;
      ticks(3);

      // Randomised traffic on both instances.
      for (int i = 0; i < 400; i++) begin
         a_load = ($urandom_range(0, 9) == 0);
         a_en   = ($urandom_range(0, 3) != 0);
         a_up   = $urandom_range(0, 1);
         a_sat  = ($urandom_range(0, 3) == 0);
         a_lv   = 4'($urandom_range(0, 15));
         b_load = ($urandom_range(0, 15) == 0);
         b_en   = ($urandom_range(0, 3) != 0);
         b_up   = $urandom_range(0, 1);
         b_sat  = ($urandom_range(0, 3) == 0);
         b_lv   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255))
                                              : 8'($urandom_range(0, 15));
         if (i == 200) begin
            async_reset();
            tick();
            rst = 1'b1;
         end else begin
            tick();
         end
      end

      #5;
      check("A queue drained", qa.size(), 0);
      check("B queue drained", qb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
